// File: rtl/dram_cmd_responder.sv
// dram_cmd_responder
//   Device-side responder for the controller's DRAM command handshake.
//   A request is sampled in IDLE: the command and the encoded one-hot
//   selects are latched, the command's latency is counted down in EXEC
//   (with the bank/buffer strobes asserted for WR/RD), and the command is
//   acknowledged in ACK until the controller drops cmd_req. An open-row
//   table (valid bit + row per bank) supplies the row for RD/WR.
//
//   Optional feature macro: DRAM_CMD_CHECK_EN
//     Adds cmd_err. Illegal commands (ACT to an open bank, RD/WR to a
//     closed bank, non-one-hot selects) still complete the handshake with
//     normal latency, but fire no strobes and leave the table untouched.
//
//   Ports
//     clk       clock, rising edge
//     rst       asynchronous active-high reset
//     cmd_req   command request (4-phase handshake)
//     cmd       2'b00 ACT, 2'b01 RD, 2'b10 WR, 2'b11 PRE
//     bank_sel  one-hot bank select
//     row_sel   one-hot row select (ACT)
//     col_sel   one-hot column select (RD/WR)
//     cmd_ack   command acknowledge
//     bank_id   encoded bank of the current command
//     row_id    ACT: encoded row_sel; otherwise the bank's stored row
//     col_id    encoded column
//     bank_rw   1 while a WR executes (write into the bank array)
//     buf_rw    1 while a RD executes (buffer drives the data bus)
//     cmd_err   (DRAM_CMD_CHECK_EN only) 1 during ACK of an illegal command
module dram_cmd_responder #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 2,
    parameter int T_CAS        = 2,
    parameter int T_RP         = 2,
    localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    localparam int RW = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1,
    localparam int CW = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    output logic                    cmd_ack,
    output logic [BW-1:0]           bank_id,
    output logic [RW-1:0]           row_id,
    output logic [CW-1:0]           col_id,
    output logic                    bank_rw,
    output logic                    buf_rw
`ifdef DRAM_CMD_CHECK_EN
    ,
    output logic                    cmd_err
`endif
);

    localparam int CNT_W = 8;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         cmd_q;
    logic               err_q;
    logic               drop_q;
    logic               ack_q;
    logic               bank_rw_q;
    logic               buf_rw_q;
    logic               cmd_err_q;
    logic [BW-1:0]      bank_id_q;
    logic [RW-1:0]      row_id_q;
    logic [CW-1:0]      col_id_q;
    logic [NUM_OF_BANKS-1:0] open_vld_q;
    logic [RW-1:0]      open_row_q [NUM_OF_BANKS];

    logic [BW-1:0]      bank_enc_d;
    logic [RW-1:0]      row_enc_d;
    logic [CW-1:0]      col_enc_d;
    logic [RW-1:0]      row_id_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               err_d;

    // Lowest set bit wins; an all-zero vector encodes to 0.
    always_comb begin
        bank_enc_d = '0;
        for (int i = NUM_OF_BANKS - 1; i >= 0; i--)
            if (bank_sel[i]) bank_enc_d = BW'(i);
    end

    always_comb begin
        row_enc_d = '0;
        for (int i = NUM_OF_ROWS - 1; i >= 0; i--)
            if (row_sel[i]) row_enc_d = RW'(i);
    end

    always_comb begin
        col_enc_d = '0;
        for (int i = NUM_OF_COLS - 1; i >= 0; i--)
            if (col_sel[i]) col_enc_d = CW'(i);
    end

    // ACT reports the row being opened; every other command reports the
    // row currently stored for the bank.
    always_comb begin
        row_id_d = open_row_q[bank_enc_d];
        if (cmd == CMD_ACT) row_id_d = row_enc_d;
    end

    // Counter preload is LAT-1 so that the ack edge lands LAT cycles after
    // the sampling edge.
    always_comb begin
        cnt_d = CNT_W'(T_RCD - 1);
        case (cmd)
            CMD_ACT: cnt_d = CNT_W'(T_RCD - 1);
            CMD_RD,
            CMD_WR:  cnt_d = CNT_W'(T_CAS - 1);
            CMD_PRE: cnt_d = CNT_W'(T_RP - 1);
            default: cnt_d = CNT_W'(T_RCD - 1);
        endcase
    end

`ifdef DRAM_CMD_CHECK_EN
    always_comb begin
        err_d = !$onehot(bank_sel);
        case (cmd)
            CMD_ACT: err_d = err_d || !$onehot(row_sel) || open_vld_q[bank_enc_d];
            CMD_RD,
            CMD_WR:  err_d = err_d || !$onehot(col_sel) || !open_vld_q[bank_enc_d];
            default: err_d = err_d;
        endcase
    end
    assign cmd_err = cmd_err_q;
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_ACT;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            ack_q      <= 1'b0;
            bank_rw_q  <= 1'b0;
            buf_rw_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            bank_id_q  <= '0;
            row_id_q   <= '0;
            col_id_q   <= '0;
            open_vld_q <= '0;
            for (int b = 0; b < NUM_OF_BANKS; b++) open_row_q[b] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_req) begin
                        cmd_q     <= cmd;
                        bank_id_q <= bank_enc_d;
                        row_id_q  <= row_id_d;
                        col_id_q  <= col_enc_d;
                        cnt_q     <= cnt_d;
                        err_q     <= err_d;
                        drop_q    <= 1'b0;
                        bank_rw_q <= (cmd == CMD_WR) && !err_d;
                        buf_rw_q  <= (cmd == CMD_RD) && !err_d;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A request released before the ack is remembered so the
                    // ack is only a single-cycle pulse.
                    if (!cmd_req) drop_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q   <= S_ACK;
                        ack_q     <= 1'b1;
                        bank_rw_q <= 1'b0;
                        buf_rw_q  <= 1'b0;
                        cmd_err_q <= err_q;
                        if (!err_q) begin
                            if (cmd_q == CMD_ACT) begin
                                open_vld_q[bank_id_q] <= 1'b1;
                                open_row_q[bank_id_q] <= row_id_q;
                            end else if (cmd_q == CMD_PRE) begin
                                open_vld_q[bank_id_q] <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ACK: begin
                    if (drop_q || !cmd_req) begin
                        state_q   <= S_IDLE;
                        ack_q     <= 1'b0;
                        cmd_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ack = ack_q;
    assign bank_rw = bank_rw_q;
    assign buf_rw  = buf_rw_q;
    assign bank_id = bank_id_q;
    assign row_id  = row_id_q;
    assign col_id  = col_id_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
module tb_dram_cmd_responder;

    localparam int L_RCD = 2, L_CAS = 2, L_RP = 2;
    localparam int M_RCD = 1, M_CAS = 3, M_RP = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_req, cmd_req2;
    logic [1:0]   cmd;
    logic [7:0]   bank_sel;
    logic [127:0] row_sel;
    logic [7:0]   col_sel;

    logic         ack, bank_rw, buf_rw;
    logic [2:0]   bank_id, col_id;
    logic [6:0]   row_id;
    logic         ack2, bank_rw2, buf_rw2;
    logic [2:0]   bank_id2, col_id2;
    logic [6:0]   row_id2;
`ifdef DRAM_CMD_CHECK_EN
    logic         cmd_err, cmd_err2;
`endif

    int ntests = 0;
    int nfail  = 0;

    // Reference model of the open-row table of the main DUT
    bit mv [8];
    int mr [8];

    always #5 clk = ~clk;

    dram_cmd_responder #(
        .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
        .T_RCD(L_RCD), .T_CAS(L_CAS), .T_RP(L_RP)
    ) dut (
        .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd(cmd),
        .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
        .cmd_ack(ack), .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
        .bank_rw(bank_rw), .buf_rw(buf_rw)
`ifdef DRAM_CMD_CHECK_EN
        , .cmd_err(cmd_err)
`endif
    );

    dram_cmd_responder #(
        .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
        .T_RCD(M_RCD), .T_CAS(M_CAS), .T_RP(M_RP)
    ) dut2 (
        .clk(clk), .rst(rst), .cmd_req(cmd_req2), .cmd(cmd),
        .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
        .cmd_ack(ack2), .bank_id(bank_id2), .row_id(row_id2), .col_id(col_id2),
        .bank_rw(bank_rw2), .buf_rw(buf_rw2)
`ifdef DRAM_CMD_CHECK_EN
        , .cmd_err(cmd_err2)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int enc(input logic [127:0] v);
        int r = 0;
        for (int i = 127; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic bit one_hot(input logic [127:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int lat_of(input logic [1:0] c, input int a, input int rw, input int p);
        if (c == 2'b00) return a;
        if (c == 2'b11) return p;
        return rw;
    endfunction

    // Drive one command to the main DUT from a negedge and check every cycle
    task automatic run1(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r,
                        input logic [7:0] col, input int hold, input bit drop_mid,
                        input bit scramble);
        int be = enc({120'd0, b});
        int ce = enc({120'd0, col});
        int lat = lat_of(c, L_RCD, L_CAS, L_RP);
        bit err = 1'b0;
        bit chk_row;
        int er;
`ifdef DRAM_CMD_CHECK_EN
        if (!one_hot({120'd0, b})) err = 1'b1;
        else if (c == 2'b00) err = mv[be] || !one_hot(r);
        else if (c != 2'b11) err = !mv[be] || !one_hot({120'd0, col});
`endif
        er = (c == 2'b00) ? enc(r) : mr[be];
        chk_row = (c == 2'b00) || ((c == 2'b01 || c == 2'b10) && mv[be]);
        cmd = c; bank_sel = b; row_sel = r; col_sel = col; cmd_req = 1'b1;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("exec_ack", int'(ack), 0);
            chk("exec_bank_rw", int'(bank_rw), int'(c == 2'b10 && !err));
            chk("exec_buf_rw", int'(buf_rw), int'(c == 2'b01 && !err));
            chk("bank_id", int'(bank_id), be);
            chk("col_id", int'(col_id), ce);
            if (chk_row) chk("row_id", int'(row_id), er);
            if (scramble) begin
                cmd = 2'($urandom); bank_sel = 8'($urandom); col_sel = 8'($urandom);
                row_sel = {4{$urandom}};
            end
            if (drop_mid && k == 0) cmd_req = 1'b0;
        end
        @(negedge clk);
        chk("ack_rise", int'(ack), 1);
        chk("ack_bank_rw", int'(bank_rw), 0);
        chk("ack_buf_rw", int'(buf_rw), 0);
`ifdef DRAM_CMD_CHECK_EN
        chk("cmd_err", int'(cmd_err), int'(err));
`endif
        if (!err) begin
            if (c == 2'b00) begin mv[be] = 1'b1; mr[be] = enc(r); end
            else if (c == 2'b11) mv[be] = 1'b0;
        end
        if (!drop_mid) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("ack_hold", int'(ack), 1);
            end
            cmd_req = 1'b0;
        end
        @(negedge clk);
        chk("ack_fall", int'(ack), 0);
`ifdef DRAM_CMD_CHECK_EN
        chk("err_fall", int'(cmd_err), 0);
`endif
        @(negedge clk);
        chk("idle_ack", int'(ack), 0);
        chk("idle_strobe", int'(bank_rw | buf_rw), 0);
    endtask

    // Latency-only check on the second DUT
    task automatic run2(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r);
        int lat = lat_of(c, M_RCD, M_CAS, M_RP);
        cmd = c; bank_sel = b; row_sel = r; col_sel = 8'h01; cmd_req2 = 1'b1;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("lat2_low", int'(ack2), 0);
        end
        @(negedge clk);
        chk("lat2_rise", int'(ack2), 1);
        cmd_req2 = 1'b0;
        @(negedge clk);
        chk("lat2_fall", int'(ack2), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r37, r5;
        r37 = 128'd1 << 37;
        r5  = 128'd1 << 5;
        for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; mr[i] = 0; end
        rst = 1'b1; cmd_req = 1'b0; cmd_req2 = 1'b0; cmd = 2'b00;
        bank_sel = '0; row_sel = '0; col_sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_ack", int'(ack), 0);
            chk("rst_rw", int'(bank_rw | buf_rw), 0);
            chk("rst_ids", int'({bank_id, row_id, col_id}), 0);
        end

        // ACT / WR / RD on bank 3, row 37, column 2
        run1(2'b00, 8'h08, r37, 8'h04, 0, 1'b0, 1'b0);
        run1(2'b10, 8'h08, r37, 8'h04, 0, 1'b0, 1'b1);
        run1(2'b01, 8'h08, 128'd0, 8'h04, 0, 1'b0, 1'b0);

        // Handshake hold for 5 cycles, then a dropped-request command
        run1(2'b01, 8'h08, 128'd0, 8'h04, 5, 1'b0, 1'b0);
        run1(2'b10, 8'h08, 128'd0, 8'h01, 0, 1'b1, 1'b0);

        // PRE then RD (illegal when checked), ACT row 5, second ACT
        run1(2'b11, 8'h08, 128'd0, 8'h01, 0, 1'b0, 1'b0);
        run1(2'b01, 8'h08, 128'd0, 8'h01, 0, 1'b0, 1'b0);
        run1(2'b00, 8'h08, r5, 8'h01, 0, 1'b0, 1'b0);
        run1(2'b00, 8'h08, r37, 8'h01, 0, 1'b0, 1'b0);

        // Async reset in the middle of a WR
        cmd = 2'b10; bank_sel = 8'h08; col_sel = 8'h02; cmd_req = 1'b1;
        @(negedge clk);
        chk("wr_before_rst", int'(bank_rw), 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_rw", int'(bank_rw), 0);
        cmd_req = 1'b0;
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_ack", int'(ack), 0);
        end
        run1(2'b01, 8'h08, 128'd0, 8'h02, 0, 1'b0, 1'b0);

        // Latency parameters on the second instance
        run2(2'b00, 8'h02, r5);
        run2(2'b01, 8'h02, 128'd0);
        run2(2'b11, 8'h02, 128'd0);

        // Randomized commands against the model
        for (int n = 0; n < 60; n++) begin
            logic [1:0]   c;
            logic [7:0]   b, col;
            logic [127:0] r;
            c = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd1 << $urandom_range(0, 7);
            r = ($urandom_range(0, 9) == 0) ? 128'd0 : 128'd1 << $urandom_range(0, 127);
            col = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd1 << $urandom_range(0, 7);
            run1(c, b, r, col, $urandom_range(0, 2), ($urandom_range(0, 7) == 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
